// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order RoB with operand-tag lookup, CDB capture, in-order retire and mispredict flush.
// Optional same-cycle CDB-to-query forwarding is enabled by defining ROB_CDB_BYPASS_EN.
module reorder_buffer #(
   parameter int unsigned BITS = 4,
   parameter int unsigned SIZE = 16,
   localparam int unsigned XLEN   = 32,
   localparam int unsigned REG_W  = 5,
   localparam int unsigned TYPE_W = 2
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic              issue_valid,
   input  logic [REG_W-1:0]  issue_rd,
   input  logic [TYPE_W-1:0] issue_type,
   input  logic [XLEN-1:0]   issue_pc,
   input  logic              issue_pred_taken,
   output logic              rob_full,
   output logic [BITS-1:0]   rob_tail,
   input  logic [BITS-1:0]   query_id_1,
   input  logic [BITS-1:0]   query_id_2,
   output logic              query_busy_1,
   output logic              query_busy_2,
   output logic [XLEN-1:0]   query_value_1,
   output logic [XLEN-1:0]   query_value_2,
   input  logic              cdb_valid,
   input  logic [BITS-1:0]   cdb_id,
   input  logic [XLEN-1:0]   cdb_value,
   input  logic              cdb_taken,
   input  logic [XLEN-1:0]   cdb_target,
   output logic              commit_valid,
   output logic [BITS-1:0]   commit_id,
   output logic [REG_W-1:0]  commit_rd,
   output logic [XLEN-1:0]   commit_value,
   output logic              commit_store,
   output logic              flush_out,
   output logic [XLEN-1:0]   flush_pc
);

   localparam int unsigned CNT_W = BITS + 1;
   localparam logic [TYPE_W-1:0] TYPE_REG    = TYPE_W'(0);
   localparam logic [TYPE_W-1:0] TYPE_STORE  = TYPE_W'(1);
   localparam logic [TYPE_W-1:0] TYPE_BRANCH = TYPE_W'(2);

   typedef struct packed {
      logic              valid;
      logic              ready;
      logic [TYPE_W-1:0] kind;
      logic [REG_W-1:0]  rd;
      logic [XLEN-1:0]   pc;
      logic              pred;
      logic [XLEN-1:0]   value;
      logic              taken;
      logic [XLEN-1:0]   target;
   } rob_entry_t;

   rob_entry_t       entry_q [SIZE];
   rob_entry_t       entry_d [SIZE];
   logic [BITS-1:0]  head_q, head_d;
   logic [BITS-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;

   rob_entry_t head_e;
   rob_entry_t q1_e;
   rob_entry_t q2_e;
   logic       do_issue;
   logic       do_cdb;
   logic       do_commit;
   logic       mispredict;

   assign rob_full   = (count_q == CNT_W'(SIZE));
   assign rob_tail   = tail_q;
   assign head_e     = entry_q[head_q];
   assign do_issue   = rdy_in && issue_valid && !rob_full;
   assign do_cdb     = rdy_in && cdb_valid && entry_q[cdb_id].valid;
   assign do_commit  = rdy_in && head_e.valid && head_e.ready;
   assign mispredict = do_commit && (head_e.kind == TYPE_BRANCH) && (head_e.taken != head_e.pred);

   // Next-state: CDB capture, allocate at tail, retire at head; a mispredict overrides everything.
   always_comb begin
      entry_d = entry_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q + CNT_W'(do_issue) - CNT_W'(do_commit);
      if (do_cdb) begin
         entry_d[cdb_id].ready  = 1'b1;
         entry_d[cdb_id].value  = cdb_value;
         entry_d[cdb_id].taken  = cdb_taken;
         entry_d[cdb_id].target = cdb_target;
      end
      if (do_issue) begin
         entry_d[tail_q] = '{valid: 1'b1, ready: 1'b0, kind: issue_type, rd: issue_rd,
                             pc: issue_pc, pred: issue_pred_taken, value: '0,
                             taken: 1'b0, target: '0};
         tail_d = tail_q + BITS'(1);
      end
      if (do_commit) begin
         entry_d[head_q].valid = 1'b0;
         entry_d[head_q].ready = 1'b0;
         head_d = head_q + BITS'(1);
      end
      if (mispredict) begin
         for (int i = 0; i < int'(SIZE); i++) begin
            entry_d[i].valid = 1'b0;
            entry_d[i].ready = 1'b0;
         end
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < int'(SIZE); i++) begin
            entry_q[i] <= '0;
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         entry_q <= entry_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Retire and flush pulses; payload holds between events.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         commit_valid <= 1'b0;
         commit_id    <= '0;
         commit_rd    <= '0;
         commit_value <= '0;
         commit_store <= 1'b0;
         flush_out    <= 1'b0;
         flush_pc     <= '0;
      end else begin
         commit_valid <= do_commit;
         flush_out    <= mispredict;
         if (do_commit) begin
            commit_id    <= head_q;
            commit_rd    <= (head_e.kind == TYPE_REG) ? head_e.rd : '0;
            commit_value <= head_e.value;
            commit_store <= (head_e.kind == TYPE_STORE);
         end
         if (mispredict) begin
            flush_pc <= head_e.taken ? head_e.target : head_e.pc + XLEN'(4);
         end
      end
   end

   assign q1_e = entry_q[query_id_1];
   assign q2_e = entry_q[query_id_2];

   // Operand-tag lookups for the reservation station.
   always_comb begin
      query_busy_1  = q1_e.valid && !q1_e.ready;
      query_value_1 = q1_e.value;
      query_busy_2  = q2_e.valid && !q2_e.ready;
      query_value_2 = q2_e.value;
`ifdef ROB_CDB_BYPASS_EN
      if (cdb_valid && (cdb_id == query_id_1) && q1_e.valid) begin
         query_busy_1  = 1'b0;
         query_value_1 = cdb_value;
      end
      if (cdb_valid && (cdb_id == query_id_2) && q2_e.valid) begin
         query_busy_2  = 1'b0;
         query_value_2 = cdb_value;
      end
`endif
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed scenarios plus random traffic against a program-order queue model.
// Expected query results follow ROB_CDB_BYPASS_EN when it is defined for the build.
module tb_reorder_buffer;

   localparam int unsigned BITS = 4;
   localparam int unsigned SIZE = 16;
`ifdef ROB_CDB_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic            clk_in = 1'b0;
   logic            rst_in;
   logic            rdy_in;
   logic            issue_valid;
   logic [4:0]      issue_rd;
   logic [1:0]      issue_type;
   logic [31:0]     issue_pc;
   logic            issue_pred_taken;
   logic            rob_full;
   logic [BITS-1:0] rob_tail;
   logic [BITS-1:0] query_id_1, query_id_2;
   logic            query_busy_1, query_busy_2;
   logic [31:0]     query_value_1, query_value_2;
   logic            cdb_valid;
   logic [BITS-1:0] cdb_id;
   logic [31:0]     cdb_value;
   logic            cdb_taken;
   logic [31:0]     cdb_target;
   logic            commit_valid;
   logic [BITS-1:0] commit_id;
   logic [4:0]      commit_rd;
   logic [31:0]     commit_value;
   logic            commit_store;
   logic            flush_out;
   logic [31:0]     flush_pc;

   reorder_buffer #(.BITS(BITS), .SIZE(SIZE)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_type(issue_type),
      .issue_pc(issue_pc), .issue_pred_taken(issue_pred_taken),
      .rob_full(rob_full), .rob_tail(rob_tail),
      .query_id_1(query_id_1), .query_id_2(query_id_2),
      .query_busy_1(query_busy_1), .query_busy_2(query_busy_2),
      .query_value_1(query_value_1), .query_value_2(query_value_2),
      .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_value(cdb_value),
      .cdb_taken(cdb_taken), .cdb_target(cdb_target),
      .commit_valid(commit_valid), .commit_id(commit_id), .commit_rd(commit_rd),
      .commit_value(commit_value), .commit_store(commit_store),
      .flush_out(flush_out), .flush_pc(flush_pc)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [1:0]  kind;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic        pred;
      logic        done;
      logic [31:0] value;
      logic        taken;
      logic [31:0] target;
   } m_entry_t;

   m_entry_t mdl [SIZE];
   int       order [$];
   int       next_id;
   int       n_checks;
   int       n_pass;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
   endtask

   function automatic bit in_flight(input int id);
      foreach (order[i]) if (order[i] == id) return 1'b1;
      return 1'b0;
   endfunction

   task automatic check_query(input string tag, input logic [BITS-1:0] id,
                              input logic busy, input logic [31:0] value);
      bit          known;
      bit          busy_e;
      logic [31:0] val_e;
      known  = in_flight(int'(id));
      busy_e = known && !mdl[id].done;
      val_e  = mdl[id].value;
      if (BYPASS && known && cdb_valid && cdb_id == id) begin
         busy_e = 1'b0;
         val_e  = cdb_value;
      end
      check({tag, "_busy"}, 32'(busy), 32'(busy_e));
      if (known && !busy_e) check({tag, "_value"}, value, val_e);
   endtask

   // One clock: check combinational outputs, predict the edge, check registered outputs, advance model.
   task automatic step();
      bit       full, do_issue, do_cdb, do_commit, misp;
      int       hid;
      m_entry_t h;
      #1;
      full = (order.size() == int'(SIZE));
      check("rob_full", 32'(rob_full), 32'(full));
      check("rob_tail", 32'(rob_tail), 32'(next_id));
      check_query("q1", query_id_1, query_busy_1, query_value_1);
      check_query("q2", query_id_2, query_busy_2, query_value_2);
      do_issue  = rdy_in && issue_valid && !full;
      do_cdb    = rdy_in && cdb_valid && in_flight(int'(cdb_id));
      do_commit = 1'b0;
      hid       = 0;
      h         = mdl[0];
      if (rdy_in && order.size() > 0) begin
         hid       = order[0];
         h         = mdl[hid];
         do_commit = h.done;
      end
      misp = do_commit && h.kind == 2'd2 && h.taken != h.pred;
      @(posedge clk_in);
      #1;
      check("commit_valid", 32'(commit_valid), 32'(do_commit));
      check("flush_out", 32'(flush_out), 32'(misp));
      if (do_commit) begin
         check("commit_id", 32'(commit_id), 32'(hid));
         check("commit_rd", 32'(commit_rd), (h.kind == 2'd0) ? 32'(h.rd) : 32'd0);
         check("commit_value", commit_value, h.value);
         check("commit_store", 32'(commit_store), 32'(h.kind == 2'd1));
      end
      if (misp) check("flush_pc", flush_pc, h.taken ? h.target : h.pc + 32'd4);
      if (misp) begin
         order.delete();
         next_id = 0;
      end else begin
         if (do_cdb) begin
            mdl[cdb_id].done   = 1'b1;
            mdl[cdb_id].value  = cdb_value;
            mdl[cdb_id].taken  = cdb_taken;
            mdl[cdb_id].target = cdb_target;
         end
         if (do_commit) void'(order.pop_front());
         if (do_issue) begin
            mdl[next_id] = '{issue_type, issue_rd, issue_pc, issue_pred_taken, 1'b0, 32'd0, 1'b0, 32'd0};
            order.push_back(next_id);
            next_id = (next_id + 1) % int'(SIZE);
         end
      end
      @(negedge clk_in);
   endtask

   task automatic set_idle();
      rdy_in = 1'b1;  issue_valid = 1'b0; issue_rd = '0; issue_type = '0;
      issue_pc = '0;  issue_pred_taken = 1'b0;
      query_id_1 = '0; query_id_2 = '0;
      cdb_valid = 1'b0; cdb_id = '0; cdb_value = '0; cdb_taken = 1'b0; cdb_target = '0;
   endtask

   task automatic issue_op(input logic [1:0] kind, input logic [4:0] rd,
                           input logic [31:0] pc, input logic pred);
      set_idle();
      issue_valid = 1'b1; issue_type = kind; issue_rd = rd;
      issue_pc = pc; issue_pred_taken = pred;
      step();
   endtask

   task automatic cdb_op(input int id, input logic [31:0] value,
                         input logic taken, input logic [31:0] target);
      set_idle();
      cdb_valid = 1'b1; cdb_id = BITS'(id); cdb_value = value;
      cdb_taken = taken; cdb_target = target;
      step();
   endtask

   task automatic idle_step();
      set_idle();
      step();
   endtask

   task automatic apply_reset();
      rst_in = 1'b0;
      #1;
      check("rst_full", 32'(rob_full), 32'd0);
      check("rst_tail", 32'(rob_tail), 32'd0);
      check("rst_commit", 32'(commit_valid), 32'd0);
      check("rst_commit_rd", 32'(commit_rd), 32'd0);
      check("rst_flush", 32'(flush_out), 32'd0);
      check("rst_flush_pc", flush_pc, 32'd0);
      check("rst_busy", 32'(query_busy_1), 32'd0);
      repeat (2) @(posedge clk_in);
      @(negedge clk_in);
      rst_in = 1'b1;
      order.delete();
      next_id = 0;
   endtask

   task automatic drain();
      int budget;
      budget = 200;
      while (order.size() > 0 && budget > 0) begin
         set_idle();
         foreach (order[i]) begin
            if (!mdl[order[i]].done && !cdb_valid) begin
               cdb_valid  = 1'b1;
               cdb_id     = BITS'(order[i]);
               cdb_value  = $urandom();
               cdb_taken  = mdl[order[i]].pred;
               cdb_target = 32'h0000_0800;
            end
         end
         step();
         budget--;
      end
      if (order.size() != 0) begin
         n_checks++;
         $display("FAIL drain_timeout: %0d entries left, required 0", order.size());
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int id6;
      n_checks = 0;
      n_pass   = 0;
      next_id  = 0;
      rst_in   = 1'b1;
      set_idle();
      #1;
      apply_reset();

      // Fill all 16 entries; the 17th issue must be ignored.
      for (int i = 0; i < int'(SIZE); i++) issue_op(2'd0, 5'(i + 1), 32'(i * 4), 1'b0);
      check("fill_full", 32'(rob_full), 32'd1);
      check("fill_tail", 32'(rob_tail), 32'd0);
      issue_op(2'd0, 5'd20, 32'h40, 1'b0);
      check("full_hold_full", 32'(rob_full), 32'd1);
      check("full_hold_tail", 32'(rob_tail), 32'd0);
      cdb_op(0, 32'hAAAA, 1'b0, 32'd0);
      apply_reset();
      check("rst_mid_no_commit", 32'(commit_valid), 32'd0);
      check("rst_mid_full", 32'(rob_full), 32'd0);

      // Single result: query then commit.
      issue_op(2'd0, 5'd5, 32'h10, 1'b0);
      cdb_op(0, 32'h1234, 1'b0, 32'd0);
      set_idle();
      query_id_1 = '0;
      #1;
      check("q0_busy", 32'(query_busy_1), 32'd0);
      check("q0_value", query_value_1, 32'h1234);
      step();
      check("c0_valid", 32'(commit_valid), 32'd1);
      check("c0_rd", 32'(commit_rd), 32'd5);
      check("c0_value", commit_value, 32'h1234);

      // Out-of-order completion retires in order.
      issue_op(2'd0, 5'd7, 32'h20, 1'b0);
      issue_op(2'd0, 5'd8, 32'h24, 1'b0);
      cdb_op(2, 32'h22, 1'b0, 32'd0);
      idle_step();
      check("ooo_wait", 32'(commit_valid), 32'd0);
      cdb_op(1, 32'h11, 1'b0, 32'd0);
      idle_step();
      check("ooo_first_id", 32'(commit_id), 32'd1);
      idle_step();
      check("ooo_second_id", 32'(commit_id), 32'd2);
      check("ooo_second_val", commit_value, 32'h22);

      // Mispredicted taken branch flushes younger entries.
      issue_op(2'd2, 5'd0, 32'h100, 1'b0);
      issue_op(2'd0, 5'd9, 32'h104, 1'b0);
      issue_op(2'd0, 5'd10, 32'h108, 1'b0);
      cdb_op(3, 32'd0, 1'b1, 32'h200);
      idle_step();
      check("br_flush", 32'(flush_out), 32'd1);
      check("br_flush_pc", flush_pc, 32'h200);
      check("br_tail", 32'(rob_tail), 32'd0);
      query_id_1 = BITS'(4);
      #1;
      check("br_gone_busy", 32'(query_busy_1), 32'd0);
      issue_op(2'd2, 5'd0, 32'h100, 1'b1);
      cdb_op(0, 32'd0, 1'b0, 32'h300);
      idle_step();
      check("nt_flush_pc", flush_pc, 32'h104);

      // Query on the tag being broadcast this cycle.
      for (int i = 0; i < 4; i++) issue_op(2'd0, 5'(i + 11), 32'(32'h400 + i * 4), 1'b0);
      set_idle();
      cdb_valid = 1'b1; cdb_id = BITS'(3); cdb_value = 32'h3333;
      query_id_1 = BITS'(3); query_id_2 = BITS'(3);
      #1;
      check("byp_busy", 32'(query_busy_1), BYPASS ? 32'd0 : 32'd1);
      if (BYPASS) check("byp_value", query_value_2, 32'h3333);
      step();
      set_idle();
      query_id_1 = BITS'(3);
      #1;
      check("post_cdb_busy", 32'(query_busy_1), 32'd0);
      check("post_cdb_value", query_value_1, 32'h3333);
      drain();

      // Stall with a ready head: nothing moves until rdy_in returns.
      id6 = next_id;
      issue_op(2'd1, 5'd12, 32'h500, 1'b0);
      cdb_op(id6, 32'h6666, 1'b0, 32'd0);
      for (int i = 0; i < 3; i++) begin
         set_idle();
         rdy_in = 1'b0;
         issue_valid = 1'b1;
         step();
         check("stall_commit", 32'(commit_valid), 32'd0);
         check("stall_tail", 32'(rob_tail), 32'((id6 + 1) % int'(SIZE)));
      end
      idle_step();
      check("stall_release", 32'(commit_valid), 32'd1);
      check("stall_value", commit_value, 32'h6666);
      check("stall_store", 32'(commit_store), 32'd1);
      check("stall_rd", 32'(commit_rd), 32'd0);

      // Random traffic.
      for (int c = 0; c < 1500; c++) begin
         int r;
         int sel;
         rdy_in           = ($urandom_range(0, 9) != 0);
         issue_valid      = ($urandom_range(0, 2) != 0);
         r                = $urandom_range(0, 9);
         issue_type       = (r < 6) ? 2'd0 : (r < 8) ? 2'd1 : 2'd2;
         issue_rd         = 5'($urandom_range(0, 31));
         issue_pc         = $urandom() & 32'hFFFF_FFFC;
         issue_pred_taken = 1'($urandom_range(0, 1));
         cdb_valid        = ($urandom_range(0, 1) == 1);
         if (order.size() > 0 && $urandom_range(0, 4) != 0)
            sel = order[$urandom_range(0, order.size() - 1)];
         else
            sel = $urandom_range(0, SIZE - 1);
         cdb_id     = BITS'(sel);
         cdb_value  = $urandom();
         cdb_target = $urandom() & 32'hFFFF_FFFC;
         if (in_flight(sel) && mdl[sel].kind == 2'd2)
            cdb_taken = ($urandom_range(0, 19) == 0) ? !mdl[sel].pred : mdl[sel].pred;
         else
            cdb_taken = 1'($urandom_range(0, 1));
         if (order.size() > 0 && $urandom_range(0, 1) == 1)
            query_id_1 = BITS'(order[$urandom_range(0, order.size() - 1)]);
         else
            query_id_1 = BITS'($urandom_range(0, SIZE - 1));
         query_id_2 = ($urandom_range(0, 3) == 0) ? cdb_id : BITS'($urandom_range(0, SIZE - 1));
         step();
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
